// File: rtl/hazardunit_mc.sv
// hazardunit_mc: hazard unit for the 5-stage RV32 pipeline.
//  - M>W operand forwarding into E.
//  - Load-use stall of LOAD_LAT bubbles (multi-cycle memory).
//  - One-entry scoreboard tracking the in-flight mul/div (MD) result.
//  - A taken branch in E overrides every D-side stall.
// Optional feature: define HAZARD_PERF_EN to add the StallCycles/FlushCount
// performance counters (CNT_W bits, wrapping, cleared by reset).
module hazardunit_mc #(
  parameter int AW       = 5,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] Rs1D,
  input  logic [AW-1:0] Rs2D,
  input  logic [AW-1:0] Rs1E,
  input  logic [AW-1:0] Rs2E,
  input  logic [AW-1:0] RdE,
  input  logic [AW-1:0] RdM,
  input  logic [AW-1:0] RdW,
  input  logic          RegWriteE,
  input  logic          RegWriteM,
  input  logic          RegWriteW,
  input  logic          ResultSrcE0,
  input  logic          PCSrcE,
  input  logic          MdStartE,
  input  logic [AW-1:0] MdRdE,
  input  logic          MdDone,
  output logic          StallF,
  output logic          StallD,
  output logic          StallE,
  output logic          FlushD,
  output logic          FlushE,
  output logic          FlushM,
  output logic [1:0]    ForwardAE,
  output logic [1:0]    ForwardBE,
`ifdef HAZARD_PERF_EN
  output logic [CNT_W-1:0] StallCycles,
  output logic [CNT_W-1:0] FlushCount,
`endif
  output logic          MdBusy
);

  // Wide enough for LOAD_LAT-1 with LOAD_LAT up to 4.
  localparam int LC_W = 3;

  logic [LC_W-1:0] ld_cnt_q, ld_cnt_d;
  logic            md_busy_q, md_busy_d;
  logic [AW-1:0]   md_rd_q, md_rd_d;
`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
  logic [CNT_W-1:0] flush_count_q, flush_count_d;
`endif

  logic ld_hit, ld_stall, md_raw, md_struct, md_accept;

  // Operand forwarding into E: the newer M result wins over W; x0 never forwards.
  always_comb begin
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    if (RegWriteM && Rs1E != '0 && Rs1E == RdM)      ForwardAE = 2'b10;
    else if (RegWriteW && Rs1E != '0 && Rs1E == RdW) ForwardAE = 2'b01;
    if (RegWriteM && Rs2E != '0 && Rs2E == RdM)      ForwardBE = 2'b10;
    else if (RegWriteW && Rs2E != '0 && Rs2E == RdW) ForwardBE = 2'b01;
  end

  // Hazard detection, stall/flush outputs and next-state for all registers.
  always_comb begin
    // NOTE: every comb output gets a default first so no path can infer a latch.
    ld_cnt_d  = ld_cnt_q;
    md_busy_d = md_busy_q;
    md_rd_d   = md_rd_q;

    ld_hit    = RegWriteE && ResultSrcE0 && RdE != '0 && (RdE == Rs1D || RdE == Rs2D);
    ld_stall  = ld_hit || (ld_cnt_q != '0);
    md_raw    = md_busy_q && md_rd_q != '0 && (md_rd_q == Rs1D || md_rd_q == Rs2D);
    md_struct = md_busy_q && MdStartE && !MdDone;

    StallE = md_struct;
    FlushM = md_struct;
    StallF = md_struct || (!PCSrcE && (ld_stall || md_raw));
    StallD = StallF;
    FlushD = PCSrcE;
    FlushE = PCSrcE || (!md_struct && (ld_stall || md_raw));
    MdBusy = md_busy_q;

    // A taken branch kills the dependent instruction, so the bubble count is dropped.
    if (PCSrcE)                ld_cnt_d = '0;
    else if (ld_hit)           ld_cnt_d = LC_W'(LOAD_LAT - 1);
    else if (ld_cnt_q != '0)   ld_cnt_d = ld_cnt_q - 1'b1;

    // A newly accepted MD op takes priority over a same-cycle completion.
    md_accept = MdStartE && !md_struct;
    if (md_accept) begin
      md_busy_d = 1'b1;
      md_rd_d   = MdRdE;
    end else if (MdDone) begin
      md_busy_d = 1'b0;
    end

`ifdef HAZARD_PERF_EN
    stall_cycles_d = stall_cycles_q + CNT_W'(StallF);
    flush_count_d  = flush_count_q + CNT_W'(FlushE);
    StallCycles    = stall_cycles_q;
    FlushCount     = flush_count_q;
`endif
  end

  // State registers with synchronous reset; reset abandons any stall or MD op.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (reset) begin
      ld_cnt_q  <= '0;
      md_busy_q <= 1'b0;
      md_rd_q   <= '0;
`ifdef HAZARD_PERF_EN
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
`endif
    end else begin
      ld_cnt_q  <= ld_cnt_d;
      md_busy_q <= md_busy_d;
      md_rd_q   <= md_rd_d;
`ifdef HAZARD_PERF_EN
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
`endif
    end
  end

endmodule

// File: tb/tb_hazardunit_mc.sv
// Directed self-checking bench for hazardunit_mc (LOAD_LAT=3).
// Perf-counter checks are built only when HAZARD_PERF_EN is defined.
module tb_hazardunit_mc;

  localparam int AW = 5;
  localparam int CNT_W = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW, MdRdE;
  logic          RegWriteE, RegWriteM, RegWriteW, ResultSrcE0, PCSrcE, MdStartE, MdDone;
  logic          StallF, StallD, StallE, FlushD, FlushE, FlushM, MdBusy;
  logic [1:0]    ForwardAE, ForwardBE;
`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] StallCycles, FlushCount;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  hazardunit_mc #(.AW(AW), .LOAD_LAT(3), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .ResultSrcE0(ResultSrcE0), .PCSrcE(PCSrcE),
    .MdStartE(MdStartE), .MdRdE(MdRdE), .MdDone(MdDone),
    .StallF(StallF), .StallD(StallD), .StallE(StallE),
    .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
`ifdef HAZARD_PERF_EN
    .StallCycles(StallCycles), .FlushCount(FlushCount),
`endif
    .MdBusy(MdBusy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle after an input change.
  task automatic settle();
    #1;
  endtask

  task automatic clear_inputs();
    Rs1D = '0; Rs2D = '0; Rs1E = '0; Rs2E = '0;
    RdE = '0; RdM = '0; RdW = '0; MdRdE = '0;
    RegWriteE = 0; RegWriteM = 0; RegWriteW = 0;
    ResultSrcE0 = 0; PCSrcE = 0; MdStartE = 0; MdDone = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic load_in_e(input logic [AW-1:0] rd);
    RegWriteE = 1; ResultSrcE0 = 1; RdE = rd;
  endtask

  task automatic bubble_in_e();
    RegWriteE = 0; ResultSrcE0 = 0; RdE = '0;
  endtask

  initial begin
    clear_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    settle();
    check("rst_mdbusy", 32'(MdBusy), 0);
    check("rst_stallf", 32'(StallF), 0);
    check("rst_flushe", 32'(FlushE), 0);
    check("rst_stalle", 32'(StallE), 0);

    // Forwarding priority: M over W, x0 never forwarded.
    Rs1E = 5; Rs2E = 5; RdM = 5; RegWriteM = 1; RdW = 5; RegWriteW = 1;
    settle();
    check("fwd_a_m", 32'(ForwardAE), 2);
    check("fwd_b_m", 32'(ForwardBE), 2);
    RegWriteM = 0;
    settle();
    check("fwd_a_w", 32'(ForwardAE), 1);
    Rs1E = 0;
    settle();
    check("fwd_a_x0", 32'(ForwardAE), 0);
    check("fwd_b_w", 32'(ForwardBE), 1);
    clear_inputs();
    settle();

    // Load-use with LOAD_LAT=3: exactly three stall cycles.
    load_in_e(7); Rs2D = 7;
    settle();
    check("ld_c0_stallf", 32'(StallF), 1);
    check("ld_c0_stalld", 32'(StallD), 1);
    check("ld_c0_flushe", 32'(FlushE), 1);
    check("ld_c0_flushd", 32'(FlushD), 0);
    tick();
    bubble_in_e();
    for (int i = 1; i <= 4; i++) begin
      settle();
      check($sformatf("ld_c%0d_stallf", i), 32'(StallF), (i < 3) ? 1 : 0);
      check($sformatf("ld_c%0d_flushe", i), 32'(FlushE), (i < 3) ? 1 : 0);
      tick();
    end
`ifdef HAZARD_PERF_EN
    check("perf_stall", StallCycles, 3);
    check("perf_flush", FlushCount, 3);
    do_reset();
    settle();
    check("perf_stall_rst", StallCycles, 0);
    check("perf_flush_rst", FlushCount, 0);
`endif
    clear_inputs();
    do_reset();

    // Load-use hit with a taken branch in the same cycle: flush only.
    load_in_e(7); Rs2D = 7; PCSrcE = 1;
    settle();
    check("ldbr_flushd", 32'(FlushD), 1);
    check("ldbr_flushe", 32'(FlushE), 1);
    check("ldbr_stallf", 32'(StallF), 0);
    tick();
    bubble_in_e(); PCSrcE = 0;
    settle();
    check("ldbr_after_stallf", 32'(StallF), 0);
    check("ldbr_after_flushe", 32'(FlushE), 0);

    // Branch arriving mid-stall cancels the remaining bubbles.
    load_in_e(7);
    tick();
    bubble_in_e(); PCSrcE = 1;
    settle();
    check("ldmid_br_stallf", 32'(StallF), 0);
    check("ldmid_br_flushe", 32'(FlushE), 1);
    tick();
    PCSrcE = 0;
    settle();
    check("ldmid_after_stallf", 32'(StallF), 0);
    clear_inputs();
    tick();

    // MD RAW: dependent instruction held until the cycle after MdDone.
    MdStartE = 1; MdRdE = 9;
    settle();
    check("md_issue_stalle", 32'(StallE), 0);
    check("md_issue_busy", 32'(MdBusy), 0);
    tick();
    MdStartE = 0; Rs1D = 9;
    settle();
    check("md_raw_busy", 32'(MdBusy), 1);
    check("md_raw_stalld", 32'(StallD), 1);
    check("md_raw_flushe", 32'(FlushE), 1);
    tick();
    MdDone = 1;
    settle();
    check("md_done_stalld", 32'(StallD), 1);
    tick();
    MdDone = 0;
    settle();
    check("md_rel_busy", 32'(MdBusy), 0);
    check("md_rel_stalld", 32'(StallD), 0);
    clear_inputs();

    // MD structural: second op waits, then is accepted with MdDone.
    MdStartE = 1; MdRdE = 9;
    tick();
    MdRdE = 12;
    settle();
    check("mds_stalle", 32'(StallE), 1);
    check("mds_flushm", 32'(FlushM), 1);
    check("mds_stallf", 32'(StallF), 1);
    check("mds_flushe", 32'(FlushE), 0);
    tick();
    settle();
    check("mds_hold_stalle", 32'(StallE), 1);
    MdDone = 1;
    settle();
    check("mds_done_stalle", 32'(StallE), 0);
    check("mds_done_stallf", 32'(StallF), 0);
    tick();
    MdStartE = 0; MdDone = 0; Rs1D = 12;
    settle();
    check("mds_new_busy", 32'(MdBusy), 1);
    check("mds_new_rd_raw", 32'(StallD), 1);
    Rs1D = 9;
    settle();
    check("mds_old_rd_noraw", 32'(StallD), 0);
    MdDone = 1;
    tick();
    MdDone = 0;
    settle();
    check("mds_clear_busy", 32'(MdBusy), 0);

    // MD op to x0: busy but no RAW; stray MdDone while idle is ignored.
    Rs1D = 0;
    MdStartE = 1; MdRdE = 0;
    tick();
    MdStartE = 0;
    settle();
    check("md_x0_busy", 32'(MdBusy), 1);
    check("md_x0_stalld", 32'(StallD), 0);
    MdDone = 1;
    tick();
    tick();
    MdDone = 0;
    settle();
    check("md_idle_done_busy", 32'(MdBusy), 0);

    // Reset mid-MD op abandons the scoreboard entry.
    MdStartE = 1; MdRdE = 9;
    tick();
    MdStartE = 0;
    do_reset();
    Rs1D = 9;
    settle();
    check("md_rst_busy", 32'(MdBusy), 0);
    check("md_rst_stalld", 32'(StallD), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Guard against a hung run.
  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
